// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: derives BCLK/LRCK from the audio master clock and shifts
// out one stereo sample pair per frame, MSB first. A one-deep holding register
// accepts samples over valid/ready; each frame wrap moves the held pair into the
// per-channel shift registers or, when nothing is held, sends silence and
// reports an underrun. While the PLL is unlocked the serial side idles at 0.
// Build option: define LJ_FORMAT_EN for left-justified framing (no one-bit
// delay after the LRCK edge); undefined selects standard I2S framing.
module i2s_tx_serializer #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SLOT_W   = 32,
  parameter int unsigned MCLK_DIV = 6
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              valid,
  output logic              ready,
  output logic              bclk,
  output logic              lrck,
  output logic              sdata,
  output logic              frame_start,
  output logic              underrun,
  output logic [15:0]       underrun_cnt
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_W;
  localparam int unsigned CW         = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int unsigned BW         = $clog2(FRAME_BITS);
  localparam int unsigned PW         = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam int unsigned PW1        = PW + 1;
  localparam int unsigned UW         = 16;
  localparam logic [DATA_W-1:0] MSB_MASK = DATA_W'(1) << (DATA_W - 1);

  logic [CW-1:0]     r_c;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_bclk;
  logic              r_lrck;
  logic              r_sdata;
  logic              r_frame_start;
  logic              r_underrun;
  logic [UW-1:0]     r_underrun_cnt;
  logic              r_hold_full;
  logic              r_ready;
  logic [DATA_W-1:0] r_hold_l;
  logic [DATA_W-1:0] r_hold_r;
  logic [DATA_W-1:0] r_sh_l;
  logic [DATA_W-1:0] r_sh_r;

  logic              w_tick;
  logic              w_half;
  logic              w_last_bit;
  logic              w_wrap;
  logic              w_load;
  logic              w_starve;
  logic              w_wr;
  logic [BW-1:0]     w_bit_nxt;
  logic              w_right_nxt;
  logic [PW-1:0]     w_p;
  logic [DATA_W-1:0] w_sh_l_nxt;
  logic [DATA_W-1:0] w_sh_r_nxt;
  logic [DATA_W-1:0] w_sel;
  logic [DATA_W-1:0] w_mask;
  logic              w_in_range;
  logic              w_sdata_nxt;

  // Divider phase, frame position and handshake decode
  always_comb begin
    w_tick      = (r_c == CW'(MCLK_DIV - 1));
    w_half      = (r_c == CW'(MCLK_DIV / 2 - 1));
    w_last_bit  = (r_bit_cnt == BW'(FRAME_BITS - 1));
    w_wrap      = pll_locked & w_tick & w_last_bit;
    w_load      = w_wrap & r_hold_full;
    w_starve    = w_wrap & ~r_hold_full;
    w_wr        = valid & ~r_hold_full;
    w_bit_nxt   = w_last_bit ? '0 : r_bit_cnt + BW'(1);
    w_right_nxt = (w_bit_nxt >= BW'(SLOT_W));
    w_p         = w_right_nxt ? PW'(w_bit_nxt - BW'(SLOT_W)) : PW'(w_bit_nxt);
  end

  // Serial bit for the upcoming BCLK period, taken from the post-load samples
  always_comb begin
    w_sh_l_nxt = r_sh_l;
    w_sh_r_nxt = r_sh_r;
    if (w_wrap) begin
      w_sh_l_nxt = r_hold_full ? r_hold_l : '0;
      w_sh_r_nxt = r_hold_full ? r_hold_r : '0;
    end
    w_sel = w_right_nxt ? w_sh_r_nxt : w_sh_l_nxt;
`ifdef LJ_FORMAT_EN
    w_in_range = ({1'b0, w_p} < PW1'(DATA_W));
    w_mask     = MSB_MASK >> w_p;
`else
    w_in_range = (w_p != '0) && ({1'b0, w_p} <= PW1'(DATA_W));
    w_mask     = MSB_MASK >> (w_p - PW'(1));
`endif
    w_sdata_nxt = w_in_range & (|(w_sel & w_mask));
  end

  // Clock divider, bit counter and serial outputs; idle while unlocked
  always_ff @(posedge refclk) begin
    if (rst || !pll_locked) begin
      r_c           <= '0;
      r_bit_cnt     <= '0;
      r_bclk        <= 1'b0;
      r_lrck        <= 1'b0;
      r_sdata       <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      r_sh_l        <= '0;
      r_sh_r        <= '0;
    end else begin
      r_frame_start <= w_wrap;
      r_underrun    <= w_starve;
      r_sh_l        <= w_sh_l_nxt;
      r_sh_r        <= w_sh_r_nxt;
      if (w_tick) begin
        r_c       <= '0;
        r_bclk    <= 1'b0;
        r_bit_cnt <= w_bit_nxt;
        r_lrck    <= w_right_nxt;
        r_sdata   <= w_sdata_nxt;
      end else begin
        r_c <= r_c + CW'(1);
        if (w_half) begin
          r_bclk <= 1'b1;
        end
      end
    end
  end

  // One-deep holding register; a load frees it, a write fills it
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
      r_ready     <= 1'b1;
    end else if (w_wr) begin
      r_hold_full <= 1'b1;
      r_ready     <= 1'b0;
      r_hold_l    <= l_data;
      r_hold_r    <= r_data;
    end
  end

  // Saturating count of frames that started with nothing to send
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_underrun_cnt <= '0;
    end else if (w_starve && (r_underrun_cnt != '1)) begin
      r_underrun_cnt <= r_underrun_cnt + UW'(1);
    end
  end

  assign ready        = r_ready;
  assign bclk         = r_bclk;
  assign lrck         = r_lrck;
  assign sdata        = r_sdata;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;

endmodule
